lza_lz_count_encoder: RTL and testbench

//  Consumer end of the LZA pre-encoding stage. Takes the pos/neg Z-indicator strings

---
 rtl/lza_lz_count_encoder.sv | 148 ++++++++++++++
 tb/tb_lza_lz_count_encoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lza_lz_count_encoder.sv
// lza_lz_count_encoder: picks the pos/neg Z-indicator string by result sign and encodes
// its leading run of 1s (Z positions) as a normalisation shift count, behind an elastic
// valid/ready stage.
// Build option LZA_ENC_PIPE2_EN: two stages (selected string, then count/flag),
// otherwise a single stage holding count/flag.
module lza_lz_count_encoder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] string_z_pos_i,
  input  logic [DATA_WIDTH-1:0] string_z_neg_i,
  input  logic                  sel_neg_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [CNT_WIDTH-1:0]  lz_cnt_o,
  output logic                  all_zero_o
);

  localparam int unsigned Levels = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned PadW   = 1 << Levels;
  localparam int unsigned PadLo  = PadW - DATA_WIDTH;

  logic [DATA_WIDTH-1:0] sel_str;
  logic [DATA_WIDTH-1:0] enc_str;
  logic [PadW-1:0]       nz_pad;
  logic [Levels-1:0]     tree_cnt;
  logic [CNT_WIDTH-1:0]  enc_cnt;
  logic                  enc_az;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  az_q;

  assign sel_str = sel_neg_i ? string_z_neg_i : string_z_pos_i;

  // Non-Z positions as 1s, MSB-aligned; padding below the LSB is marked Z so it never
  // terminates the run ahead of a real bit.
  for (genvar i = 0; i < PadW; i++) begin : g_pad
    if (i >= PadLo) begin : g_data
      assign nz_pad[i] = ~enc_str[i - PadLo];
    end else begin : g_fill
      assign nz_pad[i] = 1'b0;
    end
  end

  // Priority tree: node n at level l spans 2**l bits, node 0 holding the MSB end.
  // az = whole span is Z; cnt = Z-run length from the top of the span when az is clear.
  for (genvar l = 0; l <= Levels; l++) begin : g_lvl
    localparam int unsigned Nodes = PadW >> l;
    logic [Nodes-1:0]  az;
    logic [Levels-1:0] cnt [Nodes];
    if (l == 0) begin : g_leaf
      for (genvar n = 0; n < Nodes; n++) begin : g_n
        assign az[n]  = ~nz_pad[PadW-1-n];
        assign cnt[n] = '0;
      end
    end else begin : g_node
      localparam logic [Levels-1:0] HalfBit = Levels'(1) << (l - 1);
      for (genvar n = 0; n < Nodes; n++) begin : g_n
        assign az[n]  = g_lvl[l-1].az[2*n] & g_lvl[l-1].az[2*n+1];
        // Upper half fully Z: run continues into the lower half, offset by its size.
        assign cnt[n] = g_lvl[l-1].az[2*n] ? (g_lvl[l-1].cnt[2*n+1] | HalfBit)
                                           : g_lvl[l-1].cnt[2*n];
      end
    end
  end

  assign enc_az   = g_lvl[Levels].az[0];
  assign tree_cnt = g_lvl[Levels].cnt[0];
  assign enc_cnt  = enc_az ? CNT_WIDTH'(DATA_WIDTH) : CNT_WIDTH'(tree_cnt);

`ifdef LZA_ENC_PIPE2_EN
  logic                  s1_valid_q, s1_valid_d, s1_ready, s1_accept;
  logic                  s2_valid_q, s2_valid_d, s2_ready, s2_accept;
  logic [DATA_WIDTH-1:0] str_q;

  assign enc_str = str_q;

  // Stage handshakes: a stage is ready when empty or when it drains this cycle.
  always_comb begin
    s2_ready   = ~s2_valid_q | out_ready_i;
    s1_ready   = ~s1_valid_q | s2_ready;
    s1_accept  = in_valid_i & s1_ready;
    s2_accept  = s1_valid_q & s2_ready;
    s1_valid_d = s1_accept | (s1_valid_q & ~s2_ready);
    s2_valid_d = s2_accept | (s2_valid_q & ~out_ready_i);
  end

  // Valid bits always update; data registers load only on accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      str_q      <= '0;
      cnt_q      <= '0;
      az_q       <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_accept) begin
        str_q <= sel_str;
      end
      if (s2_accept) begin
        cnt_q <= enc_cnt;
        az_q  <= enc_az;
      end
    end
  end

  assign in_ready_o  = s1_ready;
  assign out_valid_o = s2_valid_q;
`else
  logic valid_q, valid_d, ready, accept;

  assign enc_str = sel_str;

  // Single-stage handshake; a pop and push in the same cycle keeps the stage full.
  always_comb begin
    ready   = ~valid_q | out_ready_i;
    accept  = in_valid_i & ready;
    valid_d = accept | (valid_q & ~out_ready_i);
  end

  // Valid bit always updates; count/flag load only on accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      cnt_q   <= '0;
      az_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        cnt_q <= enc_cnt;
        az_q  <= enc_az;
      end
    end
  end

  assign in_ready_o  = ready;
  assign out_valid_o = valid_q;
`endif

  assign lz_cnt_o   = cnt_q;
  assign all_zero_o = az_q;

endmodule

// File: tb/tb_lza_lz_count_encoder.sv
// Bench for lza_lz_count_encoder (DATA_WIDTH=8); latency follows LZA_ENC_PIPE2_EN.
module tb_lza_lz_count_encoder;

  localparam int W  = 8;
  localparam int CW = 4;
`ifdef LZA_ENC_PIPE2_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  z_pos = '0;
  logic [W-1:0]  z_neg = '0;
  logic          sel_neg = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] lz_cnt;
  logic          all_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lza_lz_count_encoder #(.DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .string_z_pos_i (z_pos),
    .string_z_neg_i (z_neg),
    .sel_neg_i      (sel_neg),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .lz_cnt_o       (lz_cnt),
    .all_zero_o     (all_zero)
  );

  // Reference: count 1s from the MSB down until the first 0.
  function automatic int ref_cnt(input logic [W-1:0] v);
    int n;
    n = 0;
    while (n < W && v[W-1-n] == 1'b1) n++;
    return n;
  endfunction

  // Random string whose leading run of 1s has length l.
  function automatic logic [W-1:0] gen_lead(input int l);
    int x;
    x = ((32'hFF << (W - l)) & 32'hFF) | ($urandom & (32'hFF >> (l + 1)));
    return x[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (lz_cnt !== '0) begin errors++; $display("FAIL reset_lz_cnt got=%0d want=0", lz_cnt); end
    checks++; if (all_zero !== 1'b0) begin errors++; $display("FAIL reset_all_zero got=%b want=0", all_zero); end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_encode();
    logic [W-1:0] tp [6] = '{8'hE5, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hC0};
    logic [W-1:0] tn [6] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFE, 8'h3C};
    logic         ts [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int ecnt, wc;
    for (int i = 0; i < 6; i++) begin
      out_ready = 1'b1; z_pos = tp[i]; z_neg = tn[i]; sel_neg = ts[i]; in_valid = 1'b1;
      ecnt = ref_cnt(ts[i] ? tn[i] : tp[i]);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL enc_in_ready[%0d] got=%b want=1", i, in_ready); end
      tick();
      // Scramble inputs after accept: the result must come from the captured beat.
      in_valid = 1'b0; z_pos = W'($urandom); z_neg = W'($urandom); sel_neg = ~sel_neg;
      wc = 1;
      while (out_valid !== 1'b1 && wc < 10) begin tick(); wc++; end
      checks++; if (wc !== Lat) begin errors++; $display("FAIL enc_latency[%0d] got=%0d want=%0d", i, wc, Lat); end
      checks++; if (lz_cnt !== CW'(ecnt)) begin errors++; $display("FAIL enc_lz_cnt[%0d] got=%0d want=%0d", i, lz_cnt, ecnt); end
      checks++; if (all_zero !== (ecnt == W)) begin errors++; $display("FAIL enc_all_zero[%0d] got=%b want=%b", i, all_zero, ecnt == W); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL enc_drain[%0d] got=%b want=0", i, out_valid); end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] beats [3] = '{8'h7F, 8'hFE, 8'h80};
    int expq[$];
    int sent, got, e;
    logic rdy;
    sent = 0; got = 0;
    for (int c = 0; c < 40 && got < 3; c++) begin
      out_ready = (c >= 4);
      in_valid  = (sent < 3);
      z_pos     = (sent < 3) ? beats[sent] : W'($urandom);
      z_neg     = W'($urandom);
      sel_neg   = 1'b0;
      #1;
      rdy = in_ready;
      if (c >= Lat && c <= 3) begin
        checks++; if (out_valid !== 1'b1 || lz_cnt !== '0) begin errors++; $display("FAIL stall_hold c=%0d got valid=%b cnt=%0d want valid=1 cnt=0", c, out_valid, lz_cnt); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c=%0d got=%b want=0", c, in_ready); end
      end
      if (c == 3) begin
        checks++; if (sent !== Lat) begin errors++; $display("FAIL stall_buffered got=%0d want=%0d", sent, Lat); end
      end
      if (out_valid === 1'b1 && out_ready) begin
        e = (expq.size() > 0) ? expq.pop_front() : -1;
        checks++; if (lz_cnt !== CW'(e) || e < 0) begin errors++; $display("FAIL stall_order beat=%0d got=%0d want=%0d", got, lz_cnt, e); end
        got++;
      end
      tick();
      if (in_valid && rdy) begin expq.push_back(ref_cnt(beats[sent])); sent++; end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got !== 3) begin errors++; $display("FAIL stall_count got=%0d want=3", got); end
  endtask

  task automatic test_random();
    localparam int N = 16;
    int expq[$];
    int sent, got, e, first_c, gaps;
    logic rdy;
    logic [W-1:0] v;
    sent = 0; got = 0; first_c = -1; gaps = 0;
    for (int c = 0; c < 100 && got < N; c++) begin
      out_ready = 1'b1;
      in_valid  = (sent < N);
      sel_neg   = 1'($urandom);
      v         = gen_lead($urandom_range(0, W));
      z_pos     = sel_neg ? W'($urandom) : v;
      z_neg     = sel_neg ? v : W'($urandom);
      #1;
      rdy = in_ready;
      if (first_c >= 0 && out_valid !== 1'b1) gaps++;
      if (out_valid === 1'b1) begin
        if (first_c < 0) first_c = c;
        e = (expq.size() > 0) ? expq.pop_front() : -1;
        checks++; if (e < 0 || lz_cnt !== CW'(e) || all_zero !== (e == W)) begin errors++; $display("FAIL rand_beat[%0d] got cnt=%0d az=%b want cnt=%0d az=%b", got, lz_cnt, all_zero, e, e == W); end
        got++;
      end
      tick();
      if (in_valid && rdy) begin expq.push_back(ref_cnt(v)); sent++; end
    end
    in_valid = 1'b0;
    checks++; if (got !== N) begin errors++; $display("FAIL rand_count got=%0d want=%0d", got, N); end
    checks++; if (first_c !== Lat) begin errors++; $display("FAIL rand_first got=%0d want=%0d", first_c, Lat); end
    checks++; if (gaps !== 0) begin errors++; $display("FAIL rand_throughput gaps got=%0d want=0", gaps); end
  endtask

  task automatic test_backpressure();
    localparam int N = 40;
    int expq[$];
    int sent, got, e;
    logic rdy, pv, pr, paz;
    logic [CW-1:0] pc;
    logic [W-1:0] v;
    sent = 0; got = 0; pv = 1'b0; pr = 1'b1; pc = '0; paz = 1'b0;
    for (int c = 0; c < 1000 && got < N; c++) begin
      out_ready = ($urandom_range(0, 9) < 6);
      in_valid  = (sent < N) && ($urandom_range(0, 9) < 7);
      sel_neg   = 1'($urandom);
      v         = gen_lead($urandom_range(0, W));
      z_pos     = sel_neg ? W'($urandom) : v;
      z_neg     = sel_neg ? v : W'($urandom);
      #1;
      rdy = in_ready;
      if (pv && !pr) begin
        checks++; if (out_valid !== 1'b1 || lz_cnt !== pc || all_zero !== paz) begin errors++; $display("FAIL bp_hold c=%0d got v=%b cnt=%0d az=%b want v=1 cnt=%0d az=%b", c, out_valid, lz_cnt, all_zero, pc, paz); end
      end
      if (out_valid === 1'b1 && out_ready) begin
        e = (expq.size() > 0) ? expq.pop_front() : -1;
        checks++; if (e < 0 || lz_cnt !== CW'(e) || all_zero !== (e == W)) begin errors++; $display("FAIL bp_beat[%0d] got cnt=%0d az=%b want cnt=%0d az=%b", got, lz_cnt, all_zero, e, e == W); end
        got++;
      end
      pv = out_valid; pr = out_ready; pc = lz_cnt; paz = all_zero;
      tick();
      if (in_valid && rdy) begin expq.push_back(ref_cnt(v)); sent++; end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got !== N) begin errors++; $display("FAIL bp_count got=%0d want=%0d", got, N); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_extra got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; sel_neg = 1'b0; z_pos = 8'hF0; z_neg = 8'h00;
    repeat (Lat) tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre got=%b want=1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got=%b want=0", out_valid); end
    checks++; if (lz_cnt !== '0 || all_zero !== 1'b0) begin errors++; $display("FAIL rmid_data got cnt=%0d az=%b want cnt=0 az=0", lz_cnt, all_zero); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got=%b want=1", in_ready); end
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale c=%0d got=%b want=0", c, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_stall();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
